// File: rtl/game_fsm.sv
// game_fsm: Pong game-flow controller tracking serve, play, scoring and game over.
module game_fsm #(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_TICKS = 60,
  parameter int HOR_PIXELS  = 640,
  parameter int BALL_SIZE   = 8,
  parameter int LEFT_LIMIT  = 8,
  parameter int RIGHT_LIMIT = HOR_PIXELS - BALL_SIZE - 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic        start_btn,
  input  logic [10:0] x_ball,
  output logic [1:0]  state,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic        point_scored,
  output logic        winner_left
);
  typedef enum logic [1:0] {START = 2'd0, PLAY = 2'd1, SERVE = 2'd2, GAME_OVER = 2'd3} state_t;
  state_t     state_q, state_d;
  logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [7:0] cnt_q, cnt_d;
  logic       point_q, point_d, winner_q, winner_d, prev_q;
  logic       start_edge, out_l, out_r;
  logic [3:0] inc_l, inc_r;
  assign start_edge = start_btn & ~prev_q;
  assign out_l = x_ball <= 11'(LEFT_LIMIT);
  assign out_r = x_ball >= 11'(RIGHT_LIMIT);
  assign inc_l = score_l_q + 4'd1;
  assign inc_r = score_r_q + 4'd1;
  always_comb begin
    state_d   = state_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    cnt_d     = cnt_q;
    winner_d  = winner_q;
    point_d   = 1'b0;
    case (state_q)
      START, GAME_OVER: if (start_edge) begin
        state_d   = SERVE;
        score_l_d = 4'd0;
        score_r_d = 4'd0;
        winner_d  = 1'b0;
        cnt_d     = 8'd0;
      end
      SERVE: if (timing_tick) begin
        state_d = (cnt_q == 8'(SERVE_TICKS - 1)) ? PLAY : SERVE;
        cnt_d   = (cnt_q == 8'(SERVE_TICKS - 1)) ? cnt_q : cnt_q + 8'd1;
      end
      default: if (timing_tick && (out_l || out_r)) begin
        // Left boundary wins ties so a mis-set limit pair still scores once.
        point_d   = 1'b1;
        cnt_d     = 8'd0;
        score_r_d = out_l ? inc_r : score_r_q;
        score_l_d = out_l ? score_l_q : inc_l;
        winner_d  = ~out_l;
        state_d   = ((out_l ? inc_r : inc_l) == 4'(WIN_SCORE)) ? GAME_OVER : SERVE;
        winner_d  = (state_d == GAME_OVER) ? ~out_l : winner_q;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= START;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
      cnt_q     <= 8'd0;
      point_q   <= 1'b0;
      winner_q  <= 1'b0;
      prev_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      cnt_q     <= cnt_d;
      point_q   <= point_d;
      winner_q  <= winner_d;
      prev_q    <= start_btn;
    end
  end
  assign state        = state_q;
  assign score_left   = score_l_q;
  assign score_right  = score_r_q;
  assign point_scored = point_q;
  assign winner_left  = winner_q;
endmodule
